// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central hold/bubble sequencer for the IF/ID, ID/EX and EX/M pipeline
// registers. It handles three sources of hazard: data-memory waits
// (mem_req/mem_ack), taken branches or jumps resolved in M, and EX load-use
// dependencies. It also keeps a sticky memory-timeout flag and a saturating
// count of PC-stall cycles.
//
// Handshake: mem_req is high while the M-stage instruction needs data memory.
// An access completes in any cycle where mem_req and mem_ack are both 1, so a
// zero-wait ack in the first request cycle is legal. mem_ack is ignored when
// mem_req is 0.
module pipe_hazard_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5,
   parameter int PERF_W  = 16
) (
   input  logic              CLK,
   input  logic              Resetn,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_uses_rt,
   input  logic              ex_memtoreg,
   input  logic [4:0]        ex_rd,
   input  logic              m_branch,
   input  logic              m_zero,
   input  logic              m_jump,
   input  logic              m_memwr,
   input  logic              m_memtoreg,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic              pc_stall,
   output logic              ifid_stall,
   output logic              ifid_flush,
   output logic              idex_stall,
   output logic              idex_flush,
   output logic              exm_stall,
   output logic              exm_flush,
   output logic              pc_redirect,
   output logic              timeout_err,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [1:0]        state_dbg
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MEM_WAIT = 2'd1;
   localparam logic [1:0] FLUSH    = 2'd2;
   localparam logic [1:0] ERR      = 2'd3;

   // Last wait count before an outstanding access is declared dead.
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_nxt;
   logic             err_q, err_set;
   logic             memop, taken, load_use;

   assign memop    = m_memwr | m_memtoreg;
   assign taken    = (m_branch & m_zero) | m_jump;
   assign load_use = ex_memtoreg && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

   assign state_dbg   = state;
   assign timeout_err = err_q & Resetn;

   // Per-state output decode and next-state selection; all outputs are
   // forced low while reset is asserted.
   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      err_set     = 1'b0;
      mem_req     = 1'b0;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_flush  = 1'b0;
      exm_stall   = 1'b0;
      exm_flush   = 1'b0;
      pc_redirect = 1'b0;
      if (Resetn) begin
         case (state)
            RUN, MEM_WAIT: begin
               mem_req = memop;
               if (memop && !mem_ack) begin
                  // Memory stall freezes the whole front of the pipe.
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  idex_stall = 1'b1;
                  exm_stall  = 1'b1;
                  if (state == RUN) begin
                     state_nxt = MEM_WAIT;
                     wait_nxt  = CNT_W'(1);
                  end else if (wait_cnt == WAIT_LAST) begin
                     state_nxt = ERR;
                     err_set   = 1'b1;
                  end else begin
                     wait_nxt = wait_cnt + CNT_W'(1);
                  end
               end else begin
                  wait_nxt = '0;
                  if (taken) begin
                     // Younger instructions are on the wrong path.
                     pc_redirect = 1'b1;
                     ifid_flush  = 1'b1;
                     idex_flush  = 1'b1;
                     exm_flush   = 1'b1;
                     state_nxt   = FLUSH;
                  end else begin
                     if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                     end
                     state_nxt = RUN;
                  end
               end
            end
            FLUSH: begin
               // M and EX carry bubbles this cycle, so only the ID-side
               // load-use check can still matter.
               if (load_use) begin
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  idex_flush = 1'b1;
               end
               wait_nxt  = '0;
               state_nxt = (memop && !mem_ack) ? MEM_WAIT : RUN;
            end
            default: begin
               // ERR: pipeline frozen until reset.
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
               idex_stall = 1'b1;
               exm_stall  = 1'b1;
               state_nxt  = ERR;
            end
         endcase
      end
   end

   // State, wait counter and sticky error registers.
   always_ff @(posedge CLK or negedge Resetn) begin
      if (!Resetn) begin
         state    <= RUN;
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (err_set) err_q <= 1'b1;
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge CLK or negedge Resetn) begin
      if (!Resetn) begin
         stall_cnt <= '0;
      end else if (pc_stall && (stall_cnt != {PERF_W{1'b1}})) begin
         stall_cnt <= stall_cnt + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. PERF_W is reduced to 4 so that the
// stall counter saturates within the timeout scenario.
module tb_pipe_hazard_ctrl;

   localparam int PW = 4;

   // Output vector bit order:
   // [9] mem_req [8] pc_stall [7] ifid_stall [6] ifid_flush [5] idex_stall
   // [4] idex_flush [3] exm_stall [2] exm_flush [1] pc_redirect [0] timeout_err
   localparam logic [9:0] O_NONE  = 10'b0000000000;
   localparam logic [9:0] O_LU    = 10'b0110010000;
   localparam logic [9:0] O_MEMST = 10'b1110101000;
   localparam logic [9:0] O_TAKEN = 10'b0001010110;
   localparam logic [9:0] O_REQ   = 10'b1000000000;
   localparam logic [9:0] O_ERR   = 10'b0110101001;

   localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_FLUSH = 2'd2, S_ERR = 2'd3;

   logic CLK = 1'b0;
   logic Resetn = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
   logic id_uses_rt = 0, ex_memtoreg = 0, m_branch = 0, m_zero = 0, m_jump = 0;
   logic m_memwr = 0, m_memtoreg = 0, mem_ack = 0;
   logic mem_req, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
   logic exm_stall, exm_flush, pc_redirect, timeout_err;
   logic [PW-1:0] stall_cnt;
   logic [1:0] state_dbg;
   logic [9:0] outs;

   int checks = 0;
   int errors = 0;
   logic [PW-1:0] exp_sc = '0;

   pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(5), .PERF_W(PW)) dut (
      .CLK(CLK), .Resetn(Resetn), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_memtoreg(ex_memtoreg), .ex_rd(ex_rd),
      .m_branch(m_branch), .m_zero(m_zero), .m_jump(m_jump),
      .m_memwr(m_memwr), .m_memtoreg(m_memtoreg), .mem_ack(mem_ack),
      .mem_req(mem_req), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
      .ifid_flush(ifid_flush), .idex_stall(idex_stall), .idex_flush(idex_flush),
      .exm_stall(exm_stall), .exm_flush(exm_flush), .pc_redirect(pc_redirect),
      .timeout_err(timeout_err), .stall_cnt(stall_cnt), .state_dbg(state_dbg)
   );

   assign outs = {mem_req, pc_stall, ifid_stall, ifid_flush, idex_stall,
                  idex_flush, exm_stall, exm_flush, pc_redirect, timeout_err};

   // Clock
   always #5 CLK = ~CLK;

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check outputs/state/counter for the current cycle, then advance one edge.
   task automatic cyc(input string tag, input logic [9:0] exp_o, input logic [1:0] exp_st);
      #1;
      check({tag, " outs"}, 16'(outs), 16'(exp_o));
      check({tag, " state"}, 16'(state_dbg), 16'(exp_st));
      check({tag, " stall_cnt"}, 16'(stall_cnt), 16'(exp_sc));
      @(posedge CLK);
      if (exp_o[8] && (exp_sc != {PW{1'b1}})) exp_sc++;
      #1;
   endtask

   task automatic clear_inputs();
      id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rt = 0; ex_memtoreg = 0;
      m_branch = 0; m_zero = 0; m_jump = 0; m_memwr = 0; m_memtoreg = 0; mem_ack = 0;
   endtask

   // Assert reset mid-cycle, verify the immediate effect, release after an edge.
   task automatic do_reset(input string tag);
      Resetn = 0;
      #1;
      check({tag, " rst outs"}, 16'(outs), 16'(O_NONE));
      check({tag, " rst stall_cnt"}, 16'(stall_cnt), 16'd0);
      check({tag, " rst state"}, 16'(state_dbg), 16'(S_RUN));
      exp_sc = '0;
      clear_inputs();
      @(posedge CLK);
      #1;
      Resetn = 1;
   endtask

   initial begin
      // Reset with a pending memop: request must stay low.
      m_memtoreg = 1;
      repeat (2) @(posedge CLK);
      #1;
      check("por outs", 16'(outs), 16'(O_NONE));
      check("por stall_cnt", 16'(stall_cnt), 16'd0);
      check("por state", 16'(state_dbg), 16'(S_RUN));
      m_memtoreg = 0;
      Resetn = 1;

      // Load-use through rs, then ex_rd=0, then through rt.
      ex_memtoreg = 1; ex_rd = 5'd8; id_rs = 5'd8;
      cyc("lu rs", O_LU, S_RUN);
      ex_rd = 5'd0; id_rs = 5'd0;
      cyc("lu r0", O_NONE, S_RUN);
      ex_rd = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1;
      cyc("lu rt", O_LU, S_RUN);
      id_uses_rt = 0;
      cyc("lu rt unused", O_NONE, S_RUN);
      clear_inputs();
      cyc("idle", O_NONE, S_RUN);

      // Load with ack after 3 cycles; counter starts from zero.
      do_reset("t2");
      m_memtoreg = 1;
      cyc("mw0", O_MEMST, S_RUN);
      cyc("mw1", O_MEMST, S_WAIT);
      cyc("mw2", O_MEMST, S_WAIT);
      mem_ack = 1;
      cyc("mw ack", O_REQ, S_WAIT);
      clear_inputs();
      cyc("mw done", O_NONE, S_RUN);
      check("t2 stall_cnt", 16'(stall_cnt), 16'd3);

      // Zero-wait access.
      m_memwr = 1; mem_ack = 1;
      cyc("zero wait", O_REQ, S_RUN);
      clear_inputs();

      // Taken branch, FLUSH with load-use, jump, not-taken branch.
      m_branch = 1; m_zero = 1;
      cyc("br taken", O_TAKEN, S_RUN);
      clear_inputs();
      ex_memtoreg = 1; ex_rd = 5'd4; id_rs = 5'd4;
      cyc("flush lu", O_LU, S_FLUSH);
      clear_inputs();
      cyc("after flush", O_NONE, S_RUN);
      m_jump = 1;
      cyc("jump", O_TAKEN, S_RUN);
      clear_inputs();
      cyc("jump flush", O_NONE, S_FLUSH);
      m_branch = 1; m_zero = 0;
      cyc("br not taken", O_NONE, S_RUN);
      cyc("br not taken2", O_NONE, S_RUN);
      clear_inputs();

      // Memop wait + taken + load-use together.
      m_memtoreg = 1; m_branch = 1; m_zero = 1;
      ex_memtoreg = 1; ex_rd = 5'd7; id_rs = 5'd7;
      cyc("combo s0", O_MEMST, S_RUN);
      cyc("combo s1", O_MEMST, S_WAIT);
      mem_ack = 1;
      cyc("combo ack", O_REQ | O_TAKEN, S_WAIT);
      clear_inputs();
      cyc("combo flush", O_NONE, S_FLUSH);
      cyc("combo run", O_NONE, S_RUN);

      // Reset while waiting at wait count 5.
      m_memwr = 1;
      for (int i = 0; i < 5; i++) cyc("pre rst wait", O_MEMST, (i == 0) ? S_RUN : S_WAIT);
      m_memwr = 1;
      do_reset("t6");
      cyc("t6 run", O_NONE, S_RUN);
      check("t6 no err", 16'(timeout_err), 16'd0);

      // Timeout: 16 request cycles, then sticky error; counter saturates at 15.
      m_memwr = 1;
      for (int i = 0; i < 16; i++) cyc("to wait", O_MEMST, (i == 0) ? S_RUN : S_WAIT);
      cyc("err0", O_ERR, S_ERR);
      clear_inputs();
      cyc("err1", O_ERR, S_ERR);
      cyc("err2", O_ERR, S_ERR);
      check("sat stall_cnt", 16'(stall_cnt), 16'hF);
      do_reset("t4");
      cyc("t4 run", O_NONE, S_RUN);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
